// File: rtl/tc0_prescaler.sv
// Timer/counter 0 clock-select and prescaler: turns CS0 into a one-cycle count-enable strobe,
// either from a free-running prescaler tap or from a synchronised edge on the external T0 pin.
module tc0_prescaler #(
  parameter int PSC_WIDTH   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cs,
  input  logic       psr,
  input  logic       tsm,
  input  logic       t0_pin,
  output logic       tick,
  output logic       t0_sync
);

  localparam logic [PSC_WIDTH-1:0] PSC_ONE = {{(PSC_WIDTH-1){1'b0}}, 1'b1};

  logic [PSC_WIDTH-1:0]   psc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   psr_hold;
  logic                   armed;
  logic                   s_last;
  logic                   psc_clr;
  logic                   tap8, tap64, tap256, tap1024;
  logic                   tick_next;

  assign s_last  = sync_q[SYNC_STAGES-1];
  assign t0_sync = s_last;

  // The first edge after reset acts as the prescaler clear edge, so the post-reset
  // tick timing matches a psr pulse on that edge.
  assign psc_clr = psr | (tsm & psr_hold) | ~armed;

  assign tap8    = &psc[2:0];
  assign tap64   = &psc[5:0];
  assign tap256  = &psc[7:0];
  assign tap1024 = &psc[9:0];

  always_comb begin
    tick_next = 1'b0;
    case (cs)
      3'd0:    tick_next = 1'b0;
      3'd1:    tick_next = 1'b1;
      3'd2:    tick_next = tap8;
      3'd3:    tick_next = tap64;
      3'd4:    tick_next = tap256;
      3'd5:    tick_next = tap1024;
      3'd6:    tick_next = ~s_last & prev;
      default: tick_next = s_last & ~prev;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      psc      <= '0;
      psr_hold <= 1'b0;
      tick     <= 1'b0;
    end else begin
      armed    <= 1'b1;
      psr_hold <= tsm & (psr_hold | psr);
      psc      <= psc_clr ? '0 : psc + PSC_ONE;
      tick     <= armed & tick_next;
    end
  end

  // Synchroniser and edge history run regardless of psr/tsm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], t0_pin};
      prev   <= s_last;
    end
  end

endmodule

// File: tb/tb_tc0_prescaler.sv
// Bench for tc0_prescaler: expected tick edge numbers are queued by the stimulus and
// consumed by a monitor that watches the tick strobe every cycle.
module tb_tc0_prescaler;

  logic       clk;
  logic       rst;
  logic [2:0] cs;
  logic       psr;
  logic       tsm;
  logic       t0_pin;
  logic       tick;
  logic       t0_sync;

  int         edge_n;
  int         checks;
  int         errors;
  logic [31:0] exp_q[$];

  tc0_prescaler dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .psr    (psr),
    .tsm    (tsm),
    .t0_pin (t0_pin),
    .tick   (tick),
    .t0_sync(t0_sync)
  );

  // clock / edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  // monitor: every tick must match the head of the expected queue
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0]) < edge_n) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL tick_missing: no tick seen, expected after edge %0d (now %0d)", exp_q[0], edge_n);
      void'(exp_q.pop_front());
    end
    if (tick === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL tick_spurious: tick after edge %0d, expected none", edge_n);
      end else begin
        if (int'(exp_q[0]) != edge_n) begin
          errors = errors + 1;
          $display("FAIL tick_timing: tick after edge %0d, expected after edge %0d", edge_n, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic goto_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_drained(input string name);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s: %0d expected ticks never seen", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic old_v;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    cs     = 3'd0;
    psr    = 1'b0;
    tsm    = 1'b0;
    t0_pin = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_bit("reset_tick", tick, 1'b0);
    check_bit("reset_t0_sync", t0_sync, 1'b0);
    rst = 1'b0;
    goto_edge(edge_n + 4);

    // cs=2 with psr at E0: ticks after E0+8, +16, +24
    base = edge_n + 1;
    cs = 3'd2;
    psr = 1'b1;
    exp_q.push_back(base + 8);
    exp_q.push_back(base + 16);
    exp_q.push_back(base + 24);
    goto_edge(base);
    psr = 1'b0;
    goto_edge(base + 28);
    cs = 3'd0;
    goto_edge(base + 40);
    check_drained("div8_drained");

    // cs=5 for 3000 cycles: exactly two ticks, 1024 apart, across the psc wrap
    base = edge_n + 1;
    cs = 3'd5;
    psr = 1'b1;
    exp_q.push_back(base + 1024);
    exp_q.push_back(base + 2048);
    goto_edge(base);
    psr = 1'b0;
    goto_edge(base + 3000);
    cs = 3'd0;
    goto_edge(base + 3004);
    check_drained("div1024_drained");

    // external modes: rise under cs=7, fall ignored; fall under cs=6
    base = edge_n;
    cs = 3'd7;
    goto_edge(base + 9);
    t0_pin = 1'b1;
    exp_q.push_back(base + 12);
    goto_edge(base + 10);
    check_bit("t0_sync_lag0", t0_sync, 1'b0);
    goto_edge(base + 11);
    check_bit("t0_sync_lag1", t0_sync, 1'b1);
    goto_edge(base + 20);
    t0_pin = 1'b0;
    goto_edge(base + 30);
    cs = 3'd6;
    goto_edge(base + 40);
    t0_pin = 1'b1;
    goto_edge(base + 50);
    t0_pin = 1'b0;
    exp_q.push_back(base + 53);
    goto_edge(base + 60);
    cs = 3'd0;
    goto_edge(base + 64);
    check_drained("ext_drained");

    // cs=3 with tsm hold: psr at E+5, tsm dropped after E+200, first tick after E+264
    base = edge_n;
    psr = 1'b1;
    goto_edge(base + 1);
    psr = 1'b0;
    goto_edge(base + 4);
    cs = 3'd3;
    tsm = 1'b1;
    psr = 1'b1;
    goto_edge(base + 5);
    psr = 1'b0;
    goto_edge(base + 200);
    tsm = 1'b0;
    exp_q.push_back(base + 264);
    exp_q.push_back(base + 328);
    goto_edge(base + 330);
    cs = 3'd0;
    goto_edge(base + 334);
    check_drained("tsm_drained");

    // cs=0 for 2048 cycles with T0 toggling: no ticks, t0_sync tracks the pin
    base = edge_n;
    for (int i = 0; i < 128; i++) begin
      goto_edge(base + 16 * i);
      old_v = t0_pin;
      t0_pin = ~t0_pin;
      goto_edge(base + 16 * i + 1);
      check_bit("t0_sync_hold", t0_sync, old_v);
      goto_edge(base + 16 * i + 2);
      check_bit("t0_sync_follow", t0_sync, ~old_v);
    end
    goto_edge(base + 2048);
    check_drained("stopped_drained");

    // cs=1 then async reset mid-run; ticks resume after the 2nd post-reset edge
    base = edge_n;
    cs = 3'd1;
    for (int i = 1; i <= 20; i++) exp_q.push_back(base + i);
    goto_edge(base + 20);
    #2;
    rst = 1'b1;
    #1;
    check_bit("async_rst_tick", tick, 1'b0);
    check_bit("async_rst_t0_sync", t0_sync, 1'b0);
    goto_edge(base + 22);
    rst = 1'b0;
    for (int i = 24; i <= 40; i++) exp_q.push_back(base + i);
    goto_edge(base + 40);
    cs = 3'd0;
    goto_edge(base + 44);
    check_drained("clk1_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
